// File: rtl/rv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_pkg : shared types and constants for the RV pipeline hazard logic
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv_pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] MASK_BYTE = 2'd0;
    localparam logic [1:0] MASK_HALF = 2'd1;
    localparam logic [1:0] MASK_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RMW  = 2'd1,
        ST_LU   = 2'd2,
        ST_MC   = 2'd3
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_src_match.sv
// ---------------------------------------------------------------------------
// hazard_src_match : load-use detector over NUM_RS ID-stage source operands
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_src_match
    import rv_pipe_pkg::*;
#(
    parameter int NUM_RS = 2,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [NUM_RS*REG_AW-1:0] i_rs,
    input  logic [NUM_RS-1:0]        i_rs_valid,
    input  logic                     i_ex_mem_read,
    input  logic [REG_AW-1:0]        i_ex_rd,
    output logic                     o_lu_hit
);

    logic [NUM_RS-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_cmp
            assign w_match[gi] = i_rs_valid[gi] & (i_rs[gi*REG_AW +: REG_AW] == i_ex_rd);
        end
    endgenerate

    // x0 is hardwired to zero, so a load targeting it can never be a hazard
    assign o_lu_hit = i_ex_mem_read & (i_ex_rd != '0) & (|w_match);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : registered hazard/stall FSM for the 5-stage RV pipeline
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int NUM_RS          = 2,
    parameter int REG_AW          = REG_AW_DEF,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int RMW_CYCLES      = 1,
    parameter int CNT_W           = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RS*REG_AW-1:0] id_rs,
    input  logic [NUM_RS-1:0]        id_rs_valid,
    input  logic                     ex_jump,
    input  logic                     ex_branch,
    input  logic                     ex_cond,
    input  logic                     ex_invert,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic [REG_AW-1:0]        ex_rd,
    input  logic                     mem_mem_write,
    input  logic [1:0]               mem_mask_mode,
    input  logic                     mc_busy,
    output logic                     pc_sel_taken,
    output logic                     pc_stall,
    output logic                     if_id_stall,
    output logic                     if_id_flush,
    output logic                     id_ex_stall,
    output logic                     id_ex_flush,
    output logic                     ex_mem_flush,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int C_MAX_CYC = (RMW_CYCLES > LOAD_USE_CYCLES) ? RMW_CYCLES : LOAD_USE_CYCLES;
    localparam int C_CW      = $clog2(C_MAX_CYC + 1);

    localparam logic [C_CW-1:0] C_ONE     = C_CW'(1);
    localparam logic [C_CW-1:0] C_RMW_INI = C_CW'(RMW_CYCLES - 1);
    localparam logic [C_CW-1:0] C_LU_INI  = C_CW'(LOAD_USE_CYCLES - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [C_CW-1:0]  r_cnt;
    logic [C_CW-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_taken;
    logic w_lu_hit;
    logic w_rmw_hit;
    logic w_eval_idle;
    logic w_hold_out;
    logic w_lu_out;
    logic w_taken_out;
    logic w_pc_stall;

    hazard_src_match #(
        .NUM_RS (NUM_RS),
        .REG_AW (REG_AW)
    ) u_src_match (
        .i_rs          (id_rs),
        .i_rs_valid    (id_rs_valid),
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rd       (ex_rd),
        .o_lu_hit      (w_lu_hit)
    );

    assign w_taken   = ex_jump | (ex_branch & (ex_cond ^ ex_invert));
    assign w_rmw_hit = mem_mem_write & (mem_mask_mode <= MASK_HALF) & (ex_mem_read | ex_mem_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_eval_idle = 1'b0;
        w_hold_out  = 1'b0;
        w_lu_out    = 1'b0;
        w_taken_out = 1'b0;

        case (r_state)
            ST_IDLE: w_eval_idle = 1'b1;
            ST_RMW: begin
                w_hold_out = 1'b1;
                w_cnt_nxt  = r_cnt - C_ONE;
                if (r_cnt == C_ONE) w_state_nxt = ST_IDLE;
            end
            ST_LU: begin
                w_lu_out  = 1'b1;
                w_cnt_nxt = r_cnt - C_ONE;
                if (r_cnt == C_ONE) w_state_nxt = ST_IDLE;
            end
            ST_MC: begin
                // release cycle falls straight through to the idle rules
                if (mc_busy) begin
                    w_hold_out = 1'b1;
                end else begin
                    w_eval_idle = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_eval_idle) begin
            if (w_rmw_hit) begin
                w_hold_out = 1'b1;
                if (RMW_CYCLES > 1) begin
                    w_state_nxt = ST_RMW;
                    w_cnt_nxt   = C_RMW_INI;
                end
            end else if (mc_busy) begin
                w_hold_out  = 1'b1;
                w_state_nxt = ST_MC;
            end else if (w_taken) begin
                w_taken_out = 1'b1;
            end else if (w_lu_hit) begin
                w_lu_out = 1'b1;
                if (LOAD_USE_CYCLES > 1) begin
                    w_state_nxt = ST_LU;
                    w_cnt_nxt   = C_LU_INI;
                end
            end
        end
    end

    assign w_pc_stall = (w_hold_out | w_lu_out) & ~rst;

    assign pc_sel_taken = w_taken_out & ~rst;
    assign pc_stall     = w_pc_stall;
    assign if_id_stall  = w_pc_stall;
    assign if_id_flush  = w_taken_out & ~rst;
    assign id_ex_stall  = w_hold_out & ~rst;
    assign id_ex_flush  = (w_taken_out | w_lu_out) & ~rst;
    assign ex_mem_flush = w_hold_out & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_pc_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed-vector self-checking bench for hazard_ctrl
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;
    import rv_pipe_pkg::*;

    localparam int NUM_RS = 3;
    localparam int REG_AW = 5;
    localparam int LU_CYC = 2;
    localparam int RMW_CYC = 2;
    localparam int CNT_W = 4;

    // {pc_sel_taken, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_HOLD  = 7'b0110101;
    localparam logic [6:0] C_LU    = 7'b0110010;
    localparam logic [6:0] C_TAKEN = 7'b1001010;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RS*REG_AW-1:0] id_rs;
    logic [NUM_RS-1:0]        id_rs_valid;
    logic                     ex_jump, ex_branch, ex_cond, ex_invert;
    logic                     ex_mem_read, ex_mem_write;
    logic [REG_AW-1:0]        ex_rd;
    logic                     mem_mem_write;
    logic [1:0]               mem_mask_mode;
    logic                     mc_busy;
    logic                     pc_sel_taken, pc_stall, if_id_stall, if_id_flush;
    logic                     id_ex_stall, id_ex_flush, ex_mem_flush;
    logic [CNT_W-1:0]         stall_count;
    logic [6:0]               w_outs;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(
        .NUM_RS          (NUM_RS),
        .REG_AW          (REG_AW),
        .LOAD_USE_CYCLES (LU_CYC),
        .RMW_CYCLES      (RMW_CYC),
        .CNT_W           (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rs_valid   (id_rs_valid),
        .ex_jump       (ex_jump),
        .ex_branch     (ex_branch),
        .ex_cond       (ex_cond),
        .ex_invert     (ex_invert),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_rd         (ex_rd),
        .mem_mem_write (mem_mem_write),
        .mem_mask_mode (mem_mask_mode),
        .mc_busy       (mc_busy),
        .pc_sel_taken  (pc_sel_taken),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    assign w_outs = {pc_sel_taken, pc_stall, if_id_stall, if_id_flush,
                     id_ex_stall, id_ex_flush, ex_mem_flush};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        id_rs = '0; id_rs_valid = '0;
        ex_jump = 1'b0; ex_branch = 1'b0; ex_cond = 1'b0; ex_invert = 1'b0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_rd = '0;
        mem_mem_write = 1'b0; mem_mask_mode = MASK_WORD; mc_busy = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs2,
                            input logic [2:0] vld);
        ex_mem_read = 1'b1; ex_rd = rd;
        id_rs = {rs2, 5'd31, rs0}; id_rs_valid = vld;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        step(); step();
        check_eq("rst_outs", 32'(w_outs), 32'(C_NONE));
        check_eq("rst_cnt", 32'(stall_count), 32'd0);
        mc_busy = 1'b1;
        settle();
        check_eq("rst_gate", 32'(w_outs), 32'(C_NONE));
        clr_in();

        // reset in the middle of an RMW stall
        rst = 1'b0;
        step();
        mem_mem_write = 1'b1; mem_mask_mode = MASK_BYTE; ex_mem_write = 1'b1;
        settle();
        check_eq("rmw_c1", 32'(w_outs), 32'(C_HOLD));
        step();
        clr_in();
        settle();
        check_eq("rmw_c2", 32'(w_outs), 32'(C_HOLD));
        rst = 1'b1;
        settle();
        check_eq("rst_mid", 32'(w_outs), 32'(C_NONE));
        step(); step();
        rst = 1'b0;
        settle();
        check_eq("post_rst", 32'(w_outs), 32'(C_NONE));
        check_eq("post_rst_cnt", 32'(stall_count), 32'd0);

        // load-use: two bubbles
        step();
        load_use(5'd5, 5'd5, 5'd0, 3'b001);
        settle();
        check_eq("lu_c1", 32'(w_outs), 32'(C_LU));
        step();
        check_eq("lu_c2", 32'(w_outs), 32'(C_LU));
        step();
        clr_in();
        settle();
        check_eq("lu_done", 32'(w_outs), 32'(C_NONE));
        check_eq("lu_cnt", 32'(stall_count), 32'd2);

        load_use(5'd0, 5'd0, 5'd0, 3'b001);
        settle();
        check_eq("lu_x0", 32'(w_outs), 32'(C_NONE));
        load_use(5'd5, 5'd5, 5'd0, 3'b000);
        settle();
        check_eq("lu_novld", 32'(w_outs), 32'(C_NONE));
        load_use(5'd9, 5'd1, 5'd9, 3'b100);
        settle();
        check_eq("lu_rs2_c1", 32'(w_outs), 32'(C_LU));
        step();
        check_eq("lu_rs2_c2", 32'(w_outs), 32'(C_LU));
        step();
        clr_in();
        settle();
        check_eq("lu_rs2_done", 32'(w_outs), 32'(C_NONE));
        check_eq("lu_rs2_cnt", 32'(stall_count), 32'd4);

        // branch sense
        ex_branch = 1'b1; ex_cond = 1'b0; ex_invert = 1'b1;
        settle();
        check_eq("br_inv", 32'(w_outs), 32'(C_TAKEN));
        ex_invert = 1'b0;
        settle();
        check_eq("br_nt", 32'(w_outs), 32'(C_NONE));
        ex_cond = 1'b1;
        settle();
        check_eq("br_t", 32'(w_outs), 32'(C_TAKEN));
        clr_in();

        // sub-word store RMW holds a jump, which redirects once afterwards
        step();
        mem_mem_write = 1'b1; mem_mask_mode = MASK_BYTE; ex_mem_read = 1'b1; ex_jump = 1'b1;
        settle();
        check_eq("rmwj_c1", 32'(w_outs), 32'(C_HOLD));
        step();
        mem_mem_write = 1'b0;
        settle();
        check_eq("rmwj_c2", 32'(w_outs), 32'(C_HOLD));
        step();
        check_eq("rmwj_redir", 32'(w_outs), 32'(C_TAKEN));
        step();
        clr_in();
        settle();
        check_eq("rmwj_done", 32'(w_outs), 32'(C_NONE));
        check_eq("rmwj_cnt", 32'(stall_count), 32'd6);

        mem_mem_write = 1'b1; mem_mask_mode = MASK_WORD; ex_mem_read = 1'b1; ex_jump = 1'b1;
        settle();
        check_eq("word_st", 32'(w_outs), 32'(C_TAKEN));
        mem_mask_mode = MASK_BYTE; ex_mem_read = 1'b0;
        settle();
        check_eq("byte_st_nomem", 32'(w_outs), 32'(C_TAKEN));
        clr_in();

        // multi-cycle unit with a jump waiting behind it
        step();
        mc_busy = 1'b1; ex_jump = 1'b1;
        settle();
        check_eq("mc_c1", 32'(w_outs), 32'(C_HOLD));
        step();
        check_eq("mc_c2", 32'(w_outs), 32'(C_HOLD));
        step();
        check_eq("mc_c3", 32'(w_outs), 32'(C_HOLD));
        step();
        mc_busy = 1'b0;
        settle();
        check_eq("mc_redir", 32'(w_outs), 32'(C_TAKEN));
        check_eq("mc_cnt", 32'(stall_count), 32'd9);
        step();
        clr_in();

        // saturation of the 4-bit stall counter
        mc_busy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        mc_busy = 1'b0;
        settle();
        check_eq("sat_outs", 32'(w_outs), 32'(C_NONE));
        check_eq("sat_cnt", 32'(stall_count), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard/stall controller for the in-order 5-stage RV pipeline. It replaces the purely combinational hazard logic with a small registered FSM. The FSM supports multi-cycle load-use and sub-word-store read-modify-write (RMW) stalls, a multi-cycle execute unit busy stall, a configurable number of source operands, and a stall-cycle performance counter. It sits beside the pipeline registers and drives PC select, stall and flush controls for IF/ID, ID/EX and EX/MEM.

Parameters:
NUM_RS, 2, number of ID-stage source register operands checked (3 for fused ops)
REG_AW, 5, register address width
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
RMW_CYCLES, 1, cycles the memory port is held by a byte/half store (>=1)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_rs  in  NUM_RS*REG_AW  ID-stage source addresses, operand i at [i*REG_AW +: REG_AW]
id_rs_valid  in  NUM_RS  operand i actually read
ex_jump  in  1  ID/EX holds unconditional jump
ex_branch  in  1  ID/EX holds conditional branch
ex_cond  in  1  ALU compare result bit 0
ex_invert  in  1  branch sense inverted (imm[31] encoding)
ex_mem_read  in  1  ID/EX is a load
ex_mem_write  in  1  ID/EX is a store
ex_rd  in  REG_AW  ID/EX destination
mem_mem_write  in  1  EX/MEM is a store
mem_mask_mode  in  2  EX/MEM store width: 0 byte, 1 half, 2 word
mc_busy  in  1  multi-cycle unit in EX not finished
pc_sel_taken  out  1  PC takes branch/jump target
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  bubble ID/EX
ex_mem_flush  out  1  bubble EX/MEM
stall_count  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Clock and reset: one clock clk; rst is asynchronous and active-high. While rst=1, every output is 0, the FSM is IDLE and all counters are 0. Reset asserted mid-stall aborts the stall immediately.
- Outputs are combinational from the current state and inputs, so the first stall cycle has zero latency. State and counters update on the rising edge of clk.
- Definitions:
  - taken = ex_jump | (ex_branch & (ex_cond ^ ex_invert)).
  - lu_hit = ex_mem_read & (ex_rd != 0) & (any i: id_rs_valid[i] & id_rs[i] == ex_rd). x0 never causes a hazard.
  - rmw_hit = mem_mem_write & (mem_mask_mode <= 1) & (ex_mem_read | ex_mem_write).
- States: IDLE, RMW, LU, MC. Remaining cycles are held in a down-counter of width clog2(max(RMW_CYCLES, LOAD_USE_CYCLES)+1).
- IDLE priority is rmw_hit > mc_busy > taken > lu_hit > none:
  - rmw_hit: pc_stall, if_id_stall, id_ex_stall and ex_mem_flush are 1. If RMW_CYCLES>1, go to RMW with cnt=RMW_CYCLES-1.
  - mc_busy: pc_stall, if_id_stall, id_ex_stall and ex_mem_flush are 1. Go to MC.
  - taken: pc_sel_taken, if_id_flush and id_ex_flush are 1. pc_stall is 0.
  - lu_hit: pc_stall, if_id_stall and id_ex_flush are 1. If LOAD_USE_CYCLES>1, go to LU with cnt=LOAD_USE_CYCLES-1.
  - none: all outputs 0.
- RMW state: same outputs as the rmw_hit case. cnt decrements each cycle and the FSM returns to IDLE on the edge where cnt==1. A deferred taken in ID/EX is evaluated afterwards in IDLE.
- LU state: pc_stall, if_id_stall and id_ex_flush are 1; taken is ignored because ID/EX holds a bubble. cnt decrements each cycle and the FSM returns to IDLE on the edge where cnt==1.
- MC state: same outputs as the mc_busy case while mc_busy=1. When mc_busy=0, evaluate the IDLE rules in that same cycle and go to IDLE.
- A taken branch held behind an RMW or MC stall must redirect exactly once, in the first IDLE cycle.
- stall_count increments by 1 on every edge where pc_stall=1 and saturates at all-ones (no wrap).

Decomposition:
- Shared package (rv_pipe_pkg): state encoding, mask-mode constants (MASK_BYTE=0, MASK_HALF=1, MASK_WORD=2), REG_AW default.
- One sub-module: hazard_src_match, a parametrised NUM_RS comparator producing lu_hit (combinational, x0 excluded).

Test Plan:
- Reset mid-RMW: RMW_CYCLES=3, assert rst in the 2nd stall cycle -> all outputs 0 at once; FSM IDLE and stall_count=0 after release.
- Load-use, LOAD_USE_CYCLES=2: ex_mem_read=1, ex_rd=5, id_rs[0]=5 valid -> pc_stall/if_id_stall/id_ex_flush=1 for exactly 2 cycles, then 0. Repeat with ex_rd=0, or with id_rs_valid[0]=0 -> no stall.
- Taken branch: ex_branch=1, ex_cond=0, ex_invert=1 -> pc_sel_taken/if_id_flush/id_ex_flush=1 for 1 cycle, pc_stall=0. With ex_invert=0 -> all outputs 0.
- Store-RMW vs jump: mem_mem_write=1, mem_mask_mode=0, ex_mem_read=1, ex_jump=1, RMW_CYCLES=2 -> 2 stall cycles with pc_sel_taken=0, then 1 cycle pc_sel_taken=1. Same stimulus with mem_mask_mode=2 -> immediate redirect.
- MC busy: mc_busy=1 for 3 cycles, then 0 -> 3 stall cycles with ex_mem_flush=1, then release; stall_count rises by 3.
- Saturation: CNT_W=4, 20 stall cycles -> stall_count holds 15.
